// File: rtl/adj_pkg.sv
// Shared types and default timing constants for the adjust-button conditioner.
// Auto-repeat is enabled by defining ADJ_AUTO_REPEAT_EN.
package adj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_REL
  } chan_state_t;

  typedef enum logic [1:0] {
    NONE,
    MIN,
    HOUR
  } owner_t;

  localparam int DEF_CNT_W         = 10;
  localparam int DEF_DEB_CYCLES    = 20;
  localparam int DEF_HOLD_CYCLES   = 500;
  localparam int DEF_REPEAT_CYCLES = 100;

endpackage

// File: rtl/adj_btn_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with timer, registered pulse.
// Hold-to-repeat (HELD timer compare and REPEAT state) exists only with ADJ_AUTO_REPEAT_EN.
module adj_btn_chan
  import adj_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES
`ifdef ADJ_AUTO_REPEAT_EN
  ,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic        grant,
  output logic        pulse,
  output logic        active,
  output logic        start,
  output chan_state_t state_dbg
);

  chan_state_t      state, state_n;
  logic [CNT_W-1:0] t, t_n;
  logic [1:0]       sync;
  logic             s;
  logic             pulse_n;

  assign s         = sync[1];
  assign active    = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      state <= IDLE;
      t     <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_n;
      t     <= t_n;
      pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    pulse_n = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (s && grant) begin
          state_n = DEB_PRESS;
          t_n     = CNT_W'(1);
          start   = 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_n = IDLE;
        end else if (t == CNT_W'(DEB_CYCLES)) begin
          state_n = HELD;
          t_n     = CNT_W'(1);
          pulse_n = 1'b1;
        end else begin
          t_n = t + 1'b1;
        end
      end
`ifdef ADJ_AUTO_REPEAT_EN
      HELD: begin
        if (!s) begin
          state_n = DEB_REL;
          t_n     = CNT_W'(1);
        end else if (t == CNT_W'(HOLD_CYCLES)) begin
          state_n = REPEAT;
          t_n     = CNT_W'(1);
          pulse_n = 1'b1;
        end else begin
          t_n = t + 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_n = DEB_REL;
          t_n     = CNT_W'(1);
        end else if (t == CNT_W'(REPEAT_CYCLES)) begin
          t_n     = CNT_W'(1);
          pulse_n = 1'b1;
        end else begin
          t_n = t + 1'b1;
        end
      end
`else
      HELD: begin
        if (!s) begin
          state_n = DEB_REL;
          t_n     = CNT_W'(1);
        end
      end
`endif
      DEB_REL: begin
        // A high sample during release restarts the stable-low count.
        if (s) begin
          t_n = CNT_W'(1);
        end else if (t == CNT_W'(DEB_CYCLES)) begin
          state_n = IDLE;
          t_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        t_n     = '0;
      end
    endcase
  end

endmodule

// File: rtl/adj_pulse_gen.sv
// Minute/hour adjust-button conditioner: two channels sharing one owner register.
// Hold-to-repeat is enabled by defining ADJ_AUTO_REPEAT_EN.
module adj_pulse_gen
  import adj_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_min,
  input  logic btn_hour,
  output logic adj_min_p,
  output logic adj_hour_p,
  output logic adj_busy
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > (2**CNT_W) - 1 ||
      HOLD_CYCLES > (2**CNT_W) - 1 || REPEAT_CYCLES > (2**CNT_W) - 1) begin : g_param_check
    $error("adj_pulse_gen: cycle parameter out of range for CNT_W");
  end

  owner_t      owner;
  chan_state_t min_state, hour_state;
  logic        min_grant, hour_grant;
  logic        min_start, hour_start;
  logic        min_active, hour_active;
  logic        owner_free;

  // An owner whose channel is back in IDLE no longer blocks the other channel.
  assign owner_free = (owner == NONE) ||
                      (owner == MIN  && min_state  == IDLE) ||
                      (owner == HOUR && hour_state == IDLE);
  assign min_grant  = owner_free || (owner == MIN);
  assign hour_grant = (owner_free || (owner == HOUR)) && !min_start;
  assign adj_busy   = min_active || hour_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= NONE;
    end else if (min_start) begin
      owner <= MIN;
    end else if (hour_start) begin
      owner <= HOUR;
    end else if (owner_free) begin
      owner <= NONE;
    end
  end

  adj_btn_chan #(
    .CNT_W        (CNT_W),
    .DEB_CYCLES   (DEB_CYCLES)
`ifdef ADJ_AUTO_REPEAT_EN
    ,
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_min),
    .grant    (min_grant),
    .pulse    (adj_min_p),
    .active   (min_active),
    .start    (min_start),
    .state_dbg(min_state)
  );

  adj_btn_chan #(
    .CNT_W        (CNT_W),
    .DEB_CYCLES   (DEB_CYCLES)
`ifdef ADJ_AUTO_REPEAT_EN
    ,
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_hour),
    .grant    (hour_grant),
    .pulse    (adj_hour_p),
    .active   (hour_active),
    .start    (hour_start),
    .state_dbg(hour_state)
  );

endmodule

// File: tb/tb_adj_pulse_gen.sv
// Bench for adj_pulse_gen: directed scenarios then random button traffic, checked each cycle
// against a timestamp-based reference model. Follows ADJ_AUTO_REPEAT_EN like the design.
module tb_adj_pulse_gen;

  localparam int DEB   = 4;
  localparam int HOLD  = 16;
  localparam int REP   = 8;
`ifdef ADJ_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk, rst_n, btn_min, btn_hour;
  logic adj_min_p, adj_hour_p, adj_busy;

  adj_pulse_gen #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_min   (btn_min),
    .btn_hour  (btn_hour),
    .adj_min_p (adj_min_p),
    .adj_hour_p(adj_hour_p),
    .adj_busy  (adj_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -1;

  // scoreboard: {busy, hour_p, min_p} expected after each edge
  logic [2:0] exp_q[$];

  // reference model state, index 0 = minute, 1 = hour
  // mode: 0 idle, 1 press debounce, 2 accepted/held, 3 release debounce
  int mode[2], c0[2], acc[2], last_hi[2];
  bit h1[2], h2[2];

  // observed statistics per scenario
  int cnt[2], first[2], last_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      mode[ch]    = 0;
      h1[ch]      = 1'b0;
      h2[ch]      = 1'b0;
      last_hi[ch] = -1;
    end
  endtask

  task automatic model_edge();
    int pre[2];
    bit s[2];
    bit p[2];
    bit start_min, grant;
    cyc++;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(3'b000);
      return;
    end
    pre = mode;
    for (int ch = 0; ch < 2; ch++) begin
      s[ch]  = h2[ch];
      h2[ch] = h1[ch];
      p[ch]  = 1'b0;
    end
    h1[0] = btn_min;
    h1[1] = btn_hour;
    start_min = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      grant = (ch == 0) ? (pre[1] == 0) : (pre[0] == 0 && !start_min);
      case (mode[ch])
        0: if (s[ch] && grant) begin
             mode[ch] = 1;
             c0[ch]   = cyc;
             if (ch == 0) start_min = 1'b1;
           end
        1: if (!s[ch]) mode[ch] = 0;
           else if (cyc - c0[ch] == DEB) begin
             p[ch]    = 1'b1;
             mode[ch] = 2;
             acc[ch]  = cyc;
           end
        2: if (!s[ch]) begin
             mode[ch]    = 3;
             last_hi[ch] = cyc;
           end else if (AR && cyc - acc[ch] >= HOLD && (cyc - acc[ch] - HOLD) % REP == 0) begin
             p[ch] = 1'b1;
           end
        default: if (s[ch]) last_hi[ch] = cyc;
                 else if (cyc - last_hi[ch] == DEB) mode[ch] = 0;
      endcase
    end
    exp_q.push_back({(mode[0] != 0) || (mode[1] != 0), p[1], p[0]});
  endtask

  task automatic clr_stats();
    cnt[0] = 0; cnt[1] = 0; first[0] = -1; first[1] = -1; last_busy = -1;
  endtask

  // driver: advance n edges, checking every output after each edge
  task automatic step(input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      e = exp_q.pop_front();
      check("min_p", adj_min_p, e[0]);
      check("hour_p", adj_hour_p, e[1]);
      check("busy", adj_busy, e[2]);
      check("pulse_excl", adj_min_p & adj_hour_p, 1'b0);
      if (adj_min_p) begin
        if (first[0] < 0) first[0] = cyc;
        cnt[0]++;
      end
      if (adj_hour_p) begin
        if (first[1] < 0) first[1] = cyc;
        cnt[1]++;
      end
      if (adj_busy) last_busy = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_min_p", adj_min_p, 1'b0);
    check("rst_hour_p", adj_hour_p, 1'b0);
    check("rst_busy", adj_busy, 1'b0);
    step(n);
    rst_n = 1'b1;
  endtask

  int t0, len;
  bit bouncy;

  initial begin
    rst_n = 1'b1; btn_min = 1'b0; btn_hour = 1'b0;
    model_reset();
    clr_stats();
    #2;
    do_reset(2);
    step(3);

    // clean press
    clr_stats(); t0 = cyc + 1;
    btn_min = 1'b1; step(40);
    btn_min = 1'b0; step(20);
    check("clean_cnt", cnt[0], AR ? 4 : 1);
    check("clean_first", first[0] - t0, 6);
    check("clean_busy_end", last_busy - t0, 40 + 1 + DEB);

    // bounce on hour
    clr_stats();
    btn_hour = 1'b1; step(2);
    btn_hour = 1'b0; step(1);
    t0 = cyc + 1;
    btn_hour = 1'b1; step(30);
    btn_hour = 1'b0; step(20);
    check("bounce_cnt", cnt[1], AR ? 3 : 1);
    check("bounce_first", first[1] - t0, 6);
    check("bounce_min_cnt", cnt[0], 0);

    // simultaneous rise: minute wins, hour gets a fresh press once minute is idle
    clr_stats(); t0 = cyc + 1;
    btn_min = 1'b1; btn_hour = 1'b1; step(10);
    btn_min = 1'b0; step(20);
    btn_hour = 1'b0; step(25);
    check("simul_min_cnt", cnt[0], 1);
    check("simul_min_first", first[0] - t0, 6);
    check("simul_hour_cnt", cnt[1], 1);
    check("simul_hour_first", first[1] - t0, 21);

    // release glitch
    clr_stats(); t0 = cyc + 1;
    btn_min = 1'b1; step(10);
    btn_min = 1'b0; step(2);
    btn_min = 1'b1; step(1);
    btn_min = 1'b0; step(20);
    check("glitch_cnt", cnt[0], 1);
    check("glitch_busy_end", last_busy - t0, 17);

    // reset during press debounce
    clr_stats();
    btn_min = 1'b1; step(4);
    check("rst_pre_cnt", cnt[0], 0);
    do_reset(3);
    t0 = cyc + 1;
    step(30);
    btn_min = 1'b0; step(20);
    check("rst_first", first[0] - t0, 6);
    check("rst_cnt", cnt[0], AR ? 3 : 1);

    // long hold
    clr_stats(); t0 = cyc + 1;
    btn_min = 1'b1; step(100);
    btn_min = 1'b0; step(20);
    check("long_cnt", cnt[0], AR ? 11 : 1);
    check("long_first", first[0] - t0, 6);

    // random traffic with bursts of bounce and occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      len    = $urandom_range(4, 70);
      bouncy = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, bouncy ? 2 : 30) == 0) btn_min = ~btn_min;
        if ($urandom_range(0, bouncy ? 2 : 30) == 0) btn_hour = ~btn_hour;
        if ($urandom_range(0, 400) == 0) do_reset($urandom_range(1, 3));
        else step(1);
      end
    end
    btn_min = 1'b0; btn_hour = 1'b0;
    step(40);
    check("final_busy", adj_busy, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
